share_split_unit: RTL and testbench



---
 rtl/share_split_if.sv | 27 ++
 rtl/share_split_unit.sv | 87 ++++++++
 tb/tb_share_split_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/share_split_if.sv
// Handshake bundle between the unmasked word producer, the share splitter and
// the masked core input.
interface share_split_if #(
   parameter int d     = 2,
   parameter int count = 32
);
   logic [count-1:0]       in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [count*(d-1)-1:0] rnd;
   logic                   rnd_valid;
   logic                   rnd_ready;
   logic [count*d-1:0]     sh_out;
   logic                   out_valid;
   logic                   out_ready;
   logic                   out_last;

   modport master (
      output in_data, in_valid, rnd, rnd_valid, out_ready,
      input  in_ready, rnd_ready, sh_out, out_valid, out_last
   );

   modport slave (
      input  in_data, in_valid, rnd, rnd_valid, out_ready,
      output in_ready, rnd_ready, sh_out, out_valid, out_last
   );
endinterface

// File: rtl/share_split_unit.sv
// Streaming masking encoder: splits each unmasked word into a d-share Boolean
// sharing, buffers up to two shared words and frames them into blocks.
module share_split_unit #(
   parameter int d               = 2,
   parameter int count           = 32,
   parameter int words_per_block = 4
) (
   input logic          clk,
   input logic          syn_rst,
   share_split_if.slave bus
);
   localparam int SW  = count * d;
   localparam int WCW = (words_per_block > 1) ? $clog2(words_per_block) : 1;
   localparam logic [WCW-1:0] LAST_IDX = WCW'(words_per_block - 1);

   typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

   occ_t           state;
   occ_t           state_next;
   logic [SW-1:0]  shares;
   logic [SW-1:0]  slot0;
   logic [SW-1:0]  slot1;
   logic           last0;
   logic           last1;
   logic [WCW-1:0] wcnt;
   logic           in_ready;
   logic           push;
   logic           pop;

   // Share 0 absorbs the data bit; only the shared form ever reaches a register.
   for (genvar gi = 0; gi < count; gi++) begin : g_bit
      logic [d-2:0] r;
      assign r                      = bus.rnd[(d-1)*gi +: d-1];
      assign shares[d*gi]           = bus.in_data[gi] ^ (^r);
      assign shares[d*gi+1 +: d-1]  = r;
   end

   assign in_ready      = !syn_rst && (state != TWO);
   assign push          = bus.in_valid && bus.rnd_valid && in_ready;
   assign pop           = (state != EMPTY) && bus.out_ready;
   assign bus.in_ready  = in_ready;
   assign bus.rnd_ready = push;
   assign bus.out_valid = (state != EMPTY);
   assign bus.sh_out    = slot0;
   assign bus.out_last  = last0;

   always_comb begin
      state_next = state;
      case (state)
         EMPTY:   if (push) state_next = ONE;
         ONE: begin
            if (push && !pop)      state_next = TWO;
            else if (pop && !push) state_next = EMPTY;
         end
         TWO:     if (pop) state_next = ONE;
         default: state_next = EMPTY;
      endcase
   end

   // slot0 is always the head; slot1 only fills while the head is stalled.
   always_ff @(posedge clk) begin
      if (syn_rst) begin
         state <= EMPTY;
         wcnt  <= '0;
         slot0 <= '0;
         slot1 <= '0;
         last0 <= 1'b0;
         last1 <= 1'b0;
      end else begin
         state <= state_next;
         if (push)
            wcnt <= (wcnt == LAST_IDX) ? '0 : wcnt + WCW'(1);
         if (state == TWO && pop) begin
            slot0 <= slot1;
            last0 <= last1;
         end else if (push) begin
            if (state == EMPTY || pop) begin
               slot0 <= shares;
               last0 <= (wcnt == LAST_IDX);
            end else begin
               slot1 <= shares;
               last1 <= (wcnt == LAST_IDX);
            end
         end
      end
   end
endmodule

// File: tb/tb_share_split_unit.sv
// Directed and randomized check of share_split_unit: a d=2 instance driven from
// a vector table plus corner sequences, and a d=3 instance against a scoreboard.
module tb_share_split_unit;
   logic clk;
   logic syn_rst;
   int   assertions;
   int   failures;

   share_split_if #(.d(2), .count(32)) bus2 ();
   share_split_if #(.d(3), .count(32)) bus3 ();

   share_split_unit #(.d(2), .count(32), .words_per_block(4)) dut2 (
      .clk(clk), .syn_rst(syn_rst), .bus(bus2)
   );
   share_split_unit #(.d(3), .count(32), .words_per_block(4)) dut3 (
      .clk(clk), .syn_rst(syn_rst), .bus(bus3)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic        rv;
      logic [31:0] data;
      logic [31:0] rnd;
      logic        exp_acc;
      logic        exp_ov;
      logic [31:0] exp_data;
      logic        exp_last;
   } vec_t;

   typedef struct {
      logic [31:0] data;
      logic [63:0] rnd;
      logic        last;
   } exp3_t;

   vec_t        vecs[12];
   exp3_t       q3[$];
   exp3_t       head3;
   logic [31:0] w[3];
   logic [31:0] data3;
   logic [63:0] rnd3;
   logic        iv3, rv3, ordy3, acc3, pop3;
   int          occ3, wcnt3, sent3, popped3, cyc3;

   function automatic logic [31:0] recomb2(input logic [63:0] s);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = s[2*i] ^ s[2*i+1];
      return r;
   endfunction

   function automatic logic [31:0] share2(input logic [63:0] s, input int j);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = s[2*i+j];
      return r;
   endfunction

   function automatic logic [31:0] recomb3(input logic [95:0] s);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = s[3*i] ^ s[3*i+1] ^ s[3*i+2];
      return r;
   endfunction

   function automatic logic [63:0] rndof3(input logic [95:0] s);
      logic [63:0] r;
      for (int i = 0; i < 32; i++) begin
         r[2*i]   = s[3*i+1];
         r[2*i+1] = s[3*i+2];
      end
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      assertions++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic iv, input logic [31:0] data, input logic rv,
                                input logic [31:0] rnd, input logic ordy);
      bus2.in_valid  = iv;
      bus2.in_data   = data;
      bus2.rnd_valid = rv;
      bus2.rnd       = rnd;
      bus2.out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      assertions = 0;
      failures   = 0;
      clk        = 1'b0;
      syn_rst    = 1'b1;
      applyStimulus(1'b1, 32'h0, 1'b1, 32'h0, 1'b0);
      bus3.in_valid  = 1'b0;
      bus3.in_data   = '0;
      bus3.rnd_valid = 1'b0;
      bus3.rnd       = '0;
      bus3.out_ready = 1'b0;

      vecs[0]  = '{1'b1, 1'b1, 32'h00000000, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b1, 1'b1, 32'h11111111, 32'h5A5A5A5A, 1'b1, 1'b1, 32'h11111111, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 32'h22222222, 32'h0F0F0F0F, 1'b1, 1'b1, 32'h22222222, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 32'h33333333, 32'h12345678, 1'b1, 1'b1, 32'h33333333, 1'b1};
      vecs[4]  = '{1'b1, 1'b1, 32'h3243F6A8, 32'hFFFFFFFF, 1'b1, 1'b1, 32'h3243F6A8, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 32'hDEADBEEF, 32'h87654321, 1'b0, 1'b0, 32'h00000000, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 32'hCAFEBABE, 32'h13579BDF, 1'b1, 1'b1, 32'hCAFEBABE, 1'b0};
      vecs[8]  = '{1'b1, 1'b1, 32'h0BADF00D, 32'h2468ACE0, 1'b1, 1'b1, 32'h0BADF00D, 1'b0};
      vecs[9]  = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 32'h12345678, 32'hFEDCBA98, 1'b1, 1'b1, 32'h12345678, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0};

      // Reset behaviour with a word offered throughout
      tick();
      tick();
      checkOutput("rst_in_ready", bus2.in_ready, 1'b0);
      checkOutput("rst_rnd_ready", bus2.rnd_ready, 1'b0);
      checkOutput("rst_out_valid", bus2.out_valid, 1'b0);
      checkOutput("rst_sh_out", bus2.sh_out, 64'h0);
      checkOutput("rst_out_last", bus2.out_last, 1'b0);
      syn_rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      #1;
      checkOutput("post_rst_in_ready", bus2.in_ready, 1'b1);
      checkOutput("post_rst_in_ready_d3", bus3.in_ready, 1'b1);
      tick();

      $display("[TB] table vectors, d=2");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].iv, vecs[i].data, vecs[i].rv, vecs[i].rnd, 1'b1);
         #1;
         checkOutput($sformatf("vec%0d_rnd_ready", i), bus2.rnd_ready, vecs[i].exp_acc);
         checkOutput($sformatf("vec%0d_in_ready", i), bus2.in_ready, 1'b1);
         tick();
         checkOutput($sformatf("vec%0d_out_valid", i), bus2.out_valid, vecs[i].exp_ov);
         if (vecs[i].exp_ov) begin
            checkOutput($sformatf("vec%0d_recomb", i), recomb2(bus2.sh_out), vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_last", i), bus2.out_last, vecs[i].exp_last);
            checkOutput($sformatf("vec%0d_share1", i), share2(bus2.sh_out, 1), vecs[i].rnd);
         end
         if (i == 4) begin
            checkOutput("vec4_share0", share2(bus2.sh_out, 0), 32'hCDBC0957);
         end
      end

      // Backpressure: two words fill the buffer, the third waits for a pop.
      // wcnt is 1 here, so the third word closes the block.
      $display("[TB] backpressure sequence");
      w[0] = 32'h10101010;
      w[1] = 32'h20202020;
      w[2] = 32'h30303030;
      applyStimulus(1'b1, w[0], 1'b1, 32'h0BB0_1234, 1'b0);
      #1;
      checkOutput("bp_w0_rnd_ready", bus2.rnd_ready, 1'b1);
      tick();
      checkOutput("bp_w0_out_valid", bus2.out_valid, 1'b1);
      checkOutput("bp_w0_in_ready", bus2.in_ready, 1'b1);
      checkOutput("bp_w0_recomb", recomb2(bus2.sh_out), w[0]);
      applyStimulus(1'b1, w[1], 1'b1, 32'h5566_7788, 1'b0);
      #1;
      checkOutput("bp_w1_rnd_ready", bus2.rnd_ready, 1'b1);
      tick();
      checkOutput("bp_full_in_ready", bus2.in_ready, 1'b0);
      checkOutput("bp_hold_recomb", recomb2(bus2.sh_out), w[0]);
      applyStimulus(1'b1, w[2], 1'b1, 32'h99AA_BBCC, 1'b0);
      #1;
      checkOutput("bp_w2_blocked_rnd_ready", bus2.rnd_ready, 1'b0);
      checkOutput("bp_w2_blocked_in_ready", bus2.in_ready, 1'b0);
      tick();
      checkOutput("bp_stall_out_valid", bus2.out_valid, 1'b1);
      checkOutput("bp_stall_recomb", recomb2(bus2.sh_out), w[0]);
      checkOutput("bp_stall_last", bus2.out_last, 1'b0);
      applyStimulus(1'b1, w[2], 1'b1, 32'h99AA_BBCC, 1'b1);
      #1;
      checkOutput("bp_pop_cycle_rnd_ready", bus2.rnd_ready, 1'b0);
      tick();
      checkOutput("bp_after_pop_in_ready", bus2.in_ready, 1'b1);
      checkOutput("bp_after_pop_recomb", recomb2(bus2.sh_out), w[1]);
      checkOutput("bp_after_pop_last", bus2.out_last, 1'b0);
      #1;
      checkOutput("bp_w2_rnd_ready", bus2.rnd_ready, 1'b1);
      tick();
      checkOutput("bp_w2_out_valid", bus2.out_valid, 1'b1);
      checkOutput("bp_w2_recomb", recomb2(bus2.sh_out), w[2]);
      checkOutput("bp_w2_last", bus2.out_last, 1'b1);
      checkOutput("bp_w2_share1", share2(bus2.sh_out, 1), 32'h99AA_BBCC);
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();
      checkOutput("bp_drained_out_valid", bus2.out_valid, 1'b0);

      // Mid-block reset discards buffered words and the partial block count
      $display("[TB] mid-block reset");
      applyStimulus(1'b1, 32'hABCD0001, 1'b1, 32'h1111_2222, 1'b0);
      tick();
      applyStimulus(1'b1, 32'hABCD0002, 1'b1, 32'h3333_4444, 1'b0);
      tick();
      checkOutput("mr_full_out_valid", bus2.out_valid, 1'b1);
      syn_rst = 1'b1;
      applyStimulus(1'b1, 32'hABCD0003, 1'b1, 32'h5555_6666, 1'b1);
      #1;
      checkOutput("mr_rst_in_ready", bus2.in_ready, 1'b0);
      checkOutput("mr_rst_rnd_ready", bus2.rnd_ready, 1'b0);
      tick();
      checkOutput("mr_out_valid", bus2.out_valid, 1'b0);
      checkOutput("mr_sh_out", bus2.sh_out, 64'h0);
      checkOutput("mr_out_last", bus2.out_last, 1'b0);
      syn_rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, 32'hA0000000 | 32'(k), 1'b1, $urandom, 1'b1);
         #1;
         checkOutput($sformatf("mr_blk%0d_rnd_ready", k), bus2.rnd_ready, 1'b1);
         tick();
         checkOutput($sformatf("mr_blk%0d_out_valid", k), bus2.out_valid, 1'b1);
         checkOutput($sformatf("mr_blk%0d_recomb", k), recomb2(bus2.sh_out), 32'hA0000000 | 32'(k));
         checkOutput($sformatf("mr_blk%0d_last", k), bus2.out_last, k == 3);
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      tick();

      // d=3 randomized stream against a FIFO scoreboard
      $display("[TB] randomized d=3 stream");
      occ3    = 0;
      wcnt3   = 0;
      sent3   = 0;
      popped3 = 0;
      cyc3    = 0;
      while (popped3 < 1000 && cyc3 < 20000) begin
         iv3   = (sent3 < 1000) && ($urandom_range(0, 3) != 0);
         rv3   = ($urandom_range(0, 4) != 0);
         ordy3 = ($urandom_range(0, 2) != 0);
         data3 = $urandom;
         rnd3  = {$urandom, $urandom};
         bus3.in_valid  = iv3;
         bus3.in_data   = data3;
         bus3.rnd_valid = rv3;
         bus3.rnd       = rnd3;
         bus3.out_ready = ordy3;
         #1;
         acc3 = iv3 && rv3 && (occ3 < 2);
         pop3 = (occ3 != 0) && ordy3;
         checkOutput("d3_in_ready", bus3.in_ready, occ3 < 2);
         checkOutput("d3_rnd_ready", bus3.rnd_ready, acc3);
         checkOutput("d3_out_valid", bus3.out_valid, occ3 != 0);
         if (pop3) begin
            head3 = q3.pop_front();
            checkOutput("d3_recomb", recomb3(bus3.sh_out), head3.data);
            checkOutput("d3_rnd_shares", rndof3(bus3.sh_out), head3.rnd);
            checkOutput("d3_last", bus3.out_last, head3.last);
            popped3++;
         end
         if (acc3) begin
            q3.push_back('{data3, rnd3, wcnt3 == 3});
            wcnt3 = (wcnt3 + 1) % 4;
            sent3++;
         end
         occ3 = occ3 + (acc3 ? 1 : 0) - (pop3 ? 1 : 0);
         cyc3++;
         tick();
      end
      checkOutput("d3_words_drained", popped3, 1000);
      checkOutput("d3_queue_empty", q3.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end
endmodule
